// File: rtl/helen_nios_cpu_debug_cmd_queue.sv
// System-clock side of the Nios II debug slave: synchronises TCK-domain update
// events, queues captured {IR, DR} commands and hands them out over valid/ready.
module helen_nios_cpu_debug_cmd_queue #(
   parameter int SR_W        = 38,
   parameter int IR_W        = 2,
   parameter int ACT_BIT     = 34,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               vs_udr,
   input  logic                               vs_uir,
   input  logic [IR_W-1:0]                    ir_in,
   input  logic [SR_W-1:0]                    sr,
   input  logic                               cmd_ready,
   input  logic                               clr_overflow,
   output logic                               cmd_valid,
   output logic [IR_W-1:0]                    cmd_ir,
   output logic [SR_W-1:0]                    jdo,
   output logic [(2**IR_W)-1:0]               take_action,
   output logic [(2**IR_W)-1:0]               take_no_action,
   output logic                               ir_update,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
   output logic                               overflow
);

   localparam int NCH   = 2**IR_W;
   localparam int LVL_W = $clog2(FIFO_DEPTH+1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int ENT_W = IR_W + SR_W;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

   logic [SYNC_STAGES-1:0] udr_sync_p0;
   logic [SYNC_STAGES-1:0] uir_sync_p0;
   logic [SYNC_STAGES-1:0] fill_p0;
   logic                   udr_prev_p1;
   logic                   uir_prev_p1;
   logic                   udr_armed;
   logic                   uir_armed;
   logic                   udr_lvl;
   logic                   uir_lvl;
   logic                   sync_ok;
   logic                   push;
   logic                   uir_rise;

   logic [ENT_W-1:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic                   pop;
   logic                   full;
   logic                   accept;
   logic                   drop;
   logic [NCH-1:0]         head_onehot;

   // ---- p0: synchronisers and edge detection ----
   assign udr_lvl = udr_sync_p0[SYNC_STAGES-1];
   assign uir_lvl = uir_sync_p0[SYNC_STAGES-1];
   // fill_p0 marks when the chain holds only real samples, so a level held
   // high across reset release never looks like a fresh rising edge
   assign sync_ok = fill_p0[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         udr_sync_p0 <= '0;
         uir_sync_p0 <= '0;
         fill_p0     <= '0;
         udr_prev_p1 <= 1'b0;
         uir_prev_p1 <= 1'b0;
         udr_armed   <= 1'b0;
         uir_armed   <= 1'b0;
      end else begin
         udr_sync_p0 <= {udr_sync_p0[SYNC_STAGES-2:0], vs_udr};
         uir_sync_p0 <= {uir_sync_p0[SYNC_STAGES-2:0], vs_uir};
         fill_p0     <= {fill_p0[SYNC_STAGES-2:0], 1'b1};
         udr_prev_p1 <= udr_lvl;
         uir_prev_p1 <= uir_lvl;
         udr_armed   <= udr_armed | (sync_ok & ~udr_lvl);
         uir_armed   <= uir_armed | (sync_ok & ~uir_lvl);
      end
   end

   assign push     = udr_armed & udr_lvl & ~udr_prev_p1;
   assign uir_rise = uir_armed & uir_lvl & ~uir_prev_p1;

   // ---- p1: command queue ----
   assign pop    = cmd_valid & cmd_ready;
   assign full   = (fifo_level == FULL_LVL);
   assign accept = push & (~full | pop);
   assign drop   = push & full & ~pop;

   always_ff @(posedge clk) begin
      if (accept)
         mem[wr_ptr] <= {ir_in, sr};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
         ir_update  <= 1'b0;
      end else begin
         ir_update <= uir_rise;
         if (accept)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({accept, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
         if (drop)
            overflow <= 1'b1;
         else if (clr_overflow)
            overflow <= 1'b0;
      end
   end

   // ---- p2: registered head and dequeue strobes ----
   assign head_onehot = NCH'(1) << cmd_ir;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_valid      <= 1'b0;
         cmd_ir         <= '0;
         jdo            <= '0;
         take_action    <= '0;
         take_no_action <= '0;
      end else begin
         take_action    <= (pop &&  jdo[ACT_BIT]) ? head_onehot : '0;
         take_no_action <= (pop && !jdo[ACT_BIT]) ? head_onehot : '0;
         // a pop always leaves one idle cycle before the next head is shown
         if (pop) begin
            cmd_valid <= 1'b0;
         end else if (!cmd_valid && (fifo_level != '0)) begin
            cmd_valid     <= 1'b1;
            {cmd_ir, jdo} <= mem[rd_ptr];
         end
      end
   end

endmodule

// File: tb/tb_helen_nios_cpu_debug_cmd_queue.sv
// Self-checking bench for helen_nios_cpu_debug_cmd_queue: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_helen_nios_cpu_debug_cmd_queue;

   localparam int SR_W    = 38;
   localparam int IR_W    = 2;
   localparam int ACT_BIT = 34;
   localparam int DEPTH   = 4;
   localparam int NCH     = 4;
   localparam int ENT_W   = IR_W + SR_W;
   localparam int OUT_W   = 1 + IR_W + SR_W + NCH + NCH + 1 + 3 + 1;

   typedef logic [ENT_W-1:0] ent_t;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              vs_udr;
   logic              vs_uir;
   logic [IR_W-1:0]   ir_in;
   logic [SR_W-1:0]   sr;
   logic              cmd_ready;
   logic              clr_overflow;
   logic              cmd_valid;
   logic [IR_W-1:0]   cmd_ir;
   logic [SR_W-1:0]   jdo;
   logic [NCH-1:0]    take_action;
   logic [NCH-1:0]    take_no_action;
   logic              ir_update;
   logic [2:0]        fifo_level;
   logic              overflow;

   int n_cmp = 0;
   int n_bad = 0;

   helen_nios_cpu_debug_cmd_queue #(
      .SR_W(SR_W), .IR_W(IR_W), .ACT_BIT(ACT_BIT), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir),
      .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .clr_overflow(clr_overflow),
      .cmd_valid(cmd_valid), .cmd_ir(cmd_ir), .jdo(jdo), .take_action(take_action),
      .take_no_action(take_no_action), .ir_update(ir_update), .fifo_level(fifo_level),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   // Reference model: a queue of commands plus per-edge input histories
   ent_t           m_q[$];
   bit             udr_h[$];
   bit             uir_h[$];
   logic           m_valid;
   logic [IR_W-1:0] m_ir;
   logic [SR_W-1:0] m_jdo;
   logic [NCH-1:0] m_ta, m_tna;
   logic           m_iru, m_ovf;

   task automatic model_clear();
      m_q.delete(); udr_h.delete(); uir_h.delete();
      m_valid = 0; m_ir = '0; m_jdo = '0; m_ta = '0; m_tna = '0; m_iru = 0; m_ovf = 0;
   endtask

   // Applies the rules for one rising clock edge using the inputs present now
   task automatic model_edge();
      int   e, old_size;
      bit   push, pop;
      ent_t head, popped;
      if (!reset_n) begin
         model_clear();
         return;
      end
      udr_h.push_back(vs_udr);
      uir_h.push_back(vs_uir);
      e = udr_h.size();
      // a sample taken at edge k shows up as a synchronised level two edges later;
      // the edge after a low-to-high step of that level is the push edge
      push  = (e >= 4) && udr_h[e-3] && !udr_h[e-4];
      m_iru = (e >= 4) && uir_h[e-3] && !uir_h[e-4];
      pop = m_valid && cmd_ready;
      old_size = m_q.size();
      head = (old_size > 0) ? m_q[0] : '0;
      m_ta = '0; m_tna = '0;
      if (pop) begin
         popped = m_q.pop_front();
         if (popped[ACT_BIT]) m_ta[popped[ENT_W-1 -: IR_W]] = 1'b1;
         else                 m_tna[popped[ENT_W-1 -: IR_W]] = 1'b1;
      end
      if (push && old_size == DEPTH && !pop) begin
         m_ovf = 1'b1;
      end else begin
         if (push) m_q.push_back({ir_in, sr});
         if (clr_overflow) m_ovf = 1'b0;
      end
      if (pop) m_valid = 1'b0;
      else if (!m_valid && old_size > 0) begin
         m_valid = 1'b1;
         {m_ir, m_jdo} = head;
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [SR_W-1:0] rnd_sr(bit act);
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      t[ACT_BIT] = act;
      return t[SR_W-1:0];
   endfunction

   task automatic udr_pulse(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] d);
      ir_in = ir; sr = d; vs_udr = 1'b1;
      step(); step();
      vs_udr = 1'b0;
      step(); step(); step(); step();
   endtask

   task automatic test_reset();
      reset_n = 1'b0; vs_udr = 1'b1; vs_uir = 1'b0; ir_in = '0; sr = '0;
      cmd_ready = 1'b0; clr_overflow = 1'b0;
      model_clear();
      #1;
      n_cmp++;
      if ({cmd_valid, cmd_ir, jdo, take_action, take_no_action, ir_update, fifo_level, overflow} !== '0) begin
         n_bad++; $display("FAIL reset_outputs: got valid=%b level=%0d ovf=%b jdo=%h, required all 0",
                           cmd_valid, fifo_level, overflow, jdo);
      end
      @(negedge clk);
      step(); step();
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) step();
      n_cmp++;
      if (fifo_level !== 3'd0 || cmd_valid !== 1'b0) begin
         n_bad++; $display("FAIL reset_held_udr: got level=%0d valid=%b, required level=0 valid=0",
                           fifo_level, cmd_valid);
      end
      vs_udr = 1'b0;
      for (int i = 0; i < 5; i++) step();
      n_cmp++;
      if (fifo_level !== 3'd0) begin
         n_bad++; $display("FAIL reset_no_push: got level=%0d, required 0", fifo_level);
      end
   endtask

   task automatic test_single();
      logic [SR_W-1:0] d;
      d = rnd_sr(1'b1);
      ir_in = 2'b01; sr = d; cmd_ready = 1'b1; vs_udr = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         if (k == 3) vs_udr = 1'b0;
         n_cmp++;
         if (cmd_valid !== (k == 4)) begin
            n_bad++; $display("FAIL single_latency edge %0d: got valid=%b, required %b", k, cmd_valid, k == 4);
         end
      end
      n_cmp++;
      if (cmd_ir !== 2'b01 || jdo !== d) begin
         n_bad++; $display("FAIL single_data: got ir=%0d jdo=%h, required ir=1 jdo=%h", cmd_ir, jdo, d);
      end
      step();
      n_cmp++;
      if (take_action !== 4'b0010 || take_no_action !== 4'b0000 || fifo_level !== 3'd0 || cmd_valid !== 1'b0) begin
         n_bad++; $display("FAIL single_strobe: got ta=%b tna=%b level=%0d valid=%b, required 0010 0000 0 0",
                           take_action, take_no_action, fifo_level, cmd_valid);
      end
      step();
      n_cmp++;
      if (take_action !== 4'b0000 || jdo !== d) begin
         n_bad++; $display("FAIL single_after: got ta=%b jdo=%h, required ta=0000 jdo=%h", take_action, jdo, d);
      end
      cmd_ready = 1'b0;
      step(); step();
   endtask

   task automatic test_overflow();
      logic [SR_W-1:0] exp_d [5];
      int w;
      cmd_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         exp_d[i] = rnd_sr(1'b0);
         udr_pulse(IR_W'(i % 4), exp_d[i]);
      end
      n_cmp++;
      if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
         n_bad++; $display("FAIL ovf_fill: got level=%0d ovf=%b, required level=4 ovf=1", fifo_level, overflow);
      end
      cmd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         w = 0;
         while (!cmd_valid && w < 4) begin
            cmd_ready = 1'b0; step(); cmd_ready = 1'b1; w++;
         end
         n_cmp++;
         if (cmd_valid !== 1'b1 || cmd_ir !== IR_W'(i) || jdo !== exp_d[i]) begin
            n_bad++; $display("FAIL ovf_order %0d: got valid=%b ir=%0d jdo=%h, required 1 %0d %h",
                              i, cmd_valid, cmd_ir, jdo, i, exp_d[i]);
         end
         step();
         n_cmp++;
         if (take_no_action !== (NCH'(1) << i) || take_action !== '0) begin
            n_bad++; $display("FAIL ovf_strobe %0d: got tna=%b ta=%b, required tna=%b ta=0000",
                              i, take_no_action, take_action, NCH'(1) << i);
         end
      end
      cmd_ready = 1'b0;
      step();
      n_cmp++;
      if (fifo_level !== 3'd0 || cmd_valid !== 1'b0) begin
         n_bad++; $display("FAIL ovf_drain: got level=%0d valid=%b, required 0 0", fifo_level, cmd_valid);
      end
   endtask

   task automatic test_full_push_pop();
      clr_overflow = 1'b1; step(); clr_overflow = 1'b0;
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_bad++; $display("FAIL clr_overflow: got %b, required 0", overflow);
      end
      for (int i = 0; i < 4; i++) udr_pulse(IR_W'(3 - i), rnd_sr($urandom_range(0, 1) == 1));
      ir_in = 2'b10; sr = rnd_sr(1'b1); vs_udr = 1'b1;
      step(); step();
      vs_udr = 1'b0; cmd_ready = 1'b1;
      step();
      cmd_ready = 1'b0;
      n_cmp++;
      if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
         n_bad++; $display("FAIL full_push_pop: got level=%0d ovf=%b, required level=4 ovf=0", fifo_level, overflow);
      end
      step(); step(); step();
      vs_udr = 1'b1;
      step(); step();
      vs_udr = 1'b0; clr_overflow = 1'b1;
      step();
      clr_overflow = 1'b0;
      n_cmp++;
      if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
         n_bad++; $display("FAIL drop_vs_clear: got level=%0d ovf=%b, required level=4 ovf=1", fifo_level, overflow);
      end
      step(); step();
      cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
      step();
      n_cmp++;
      if (fifo_level !== 3'd3) begin
         n_bad++; $display("FAIL pop_to_three: got level=%0d, required 3", fifo_level);
      end
   endtask

   task automatic test_ir_update();
      vs_uir = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         if (k == 2) vs_uir = 1'b0;
         n_cmp++;
         if (ir_update !== (k == 3)) begin
            n_bad++; $display("FAIL ir_update edge %0d: got %b, required %b", k, ir_update, k == 3);
         end
      end
      n_cmp++;
      if (fifo_level !== 3'd3) begin
         n_bad++; $display("FAIL uir_level: got level=%0d, required 3", fifo_level);
      end
   endtask

   task automatic test_async_reset();
      #2;
      reset_n = 1'b0;
      model_clear();
      #1;
      n_cmp++;
      if ({cmd_valid, cmd_ir, jdo, take_action, take_no_action, ir_update, fifo_level, overflow} !== '0) begin
         n_bad++; $display("FAIL async_reset: got valid=%b level=%0d jdo=%h, required all 0",
                           cmd_valid, fifo_level, jdo);
      end
      @(negedge clk);
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) step();
   endtask

   task automatic test_random();
      int since_raise = 6;
      int hi_len = 1;
      logic [OUT_W-1:0] got, want;
      for (int c = 0; c < 1500; c++) begin
         if (vs_udr && since_raise >= hi_len) vs_udr = 1'b0;
         else if (!vs_udr && since_raise >= 6 && $urandom_range(0, 2) == 0) begin
            vs_udr = 1'b1; since_raise = 0; hi_len = $urandom_range(1, 3);
            ir_in = IR_W'($urandom_range(0, 3)); sr = rnd_sr($urandom_range(0, 1) == 1);
         end
         if ($urandom_range(0, 3) == 0) vs_uir = ~vs_uir;
         cmd_ready = ($urandom_range(0, 2) != 0) ? (c % 400 < 300) : 1'b0;
         clr_overflow = ($urandom_range(0, 9) == 0);
         step();
         since_raise++;
         got  = {cmd_valid, cmd_ir, jdo, take_action, take_no_action, ir_update, fifo_level, overflow};
         want = {m_valid, m_ir, m_jdo, m_ta, m_tna, m_iru, 3'(m_q.size()), m_ovf};
         n_cmp++;
         if (got !== want) begin
            n_bad++; $display("FAIL random cycle %0d: got %h, required %h", c, got, want);
         end
      end
      cmd_ready = 1'b0; clr_overflow = 1'b0; vs_udr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_full_push_pop();
      test_ir_update();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
